// File: rtl/regex_job_loader.sv
// Job sequencer in front of AXI_top: packs (type,data) entries into 32-bit words, writes
// the regex code and the input string into AXI_top memory, starts the matcher and returns the verdict.
module regex_job_loader #(
  parameter int                   REG_WIDTH       = 32,
  parameter logic [REG_WIDTH-1:0] CODE_BASE       = '0,
  parameter int                   STRING_GAP      = 2,
  parameter int                   START_TIMEOUT   = 1024,
  // Command and status encodings; these must match the values AXI_top uses.
  parameter logic [REG_WIDTH-1:0] CMD_NOP         = REG_WIDTH'(0),
  parameter logic [REG_WIDTH-1:0] CMD_WRITE       = REG_WIDTH'(1),
  parameter logic [REG_WIDTH-1:0] CMD_START       = REG_WIDTH'(2),
  parameter logic [REG_WIDTH-1:0] STATUS_RUNNING  = REG_WIDTH'(1),
  parameter logic [REG_WIDTH-1:0] STATUS_ACCEPTED = REG_WIDTH'(2),
  parameter logic [REG_WIDTH-1:0] STATUS_REJECTED = REG_WIDTH'(3)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [15:0]          s_data,
  input  logic                 s_last,
  output logic [REG_WIDTH-1:0] address_register,
  output logic [REG_WIDTH-1:0] data_in_register,
  output logic [REG_WIDTH-1:0] start_cc_pointer_register,
  output logic [REG_WIDTH-1:0] cmd_register,
  input  logic [REG_WIDTH-1:0] status_register,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_accept,
  output logic                 res_error,
  output logic                 busy
);

  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    COLLECT_LO, COLLECT_HI, WR, WR_NOP, START, RUN, DONE
  } state_t;

  state_t               state;
  logic                 phase;      // 0 = code section, 1 = string section
  logic                 last_seen;
  logic [REG_WIDTH-1:0] addr;
  logic [REG_WIDTH-1:0] str_base;
  logic [15:0]          word_lo;
  logic [TW-1:0]        timer;
  logic                 handshake;
  logic [REG_WIDTH-1:0] next_str_base;

  assign handshake = s_valid && s_ready;
  // The string starts one word past the last code word, plus the configured gap.
  assign next_str_base = addr + REG_WIDTH'(2) + REG_WIDTH'(STRING_GAP);

  // NOTE: every register here is updated with <= so all branches see the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                     <= COLLECT_LO;
      phase                     <= 1'b0;
      last_seen                 <= 1'b0;
      addr                      <= CODE_BASE;
      str_base                  <= '0;
      word_lo                   <= '0;
      timer                     <= '0;
      s_ready                   <= 1'b0;
      address_register          <= '0;
      data_in_register          <= '0;
      start_cc_pointer_register <= '0;
      cmd_register              <= CMD_NOP;
      res_valid                 <= 1'b0;
      res_accept                <= 1'b0;
      res_error                 <= 1'b0;
      busy                      <= 1'b0;
    end else begin
      case (state)
        COLLECT_LO: begin
          s_ready <= 1'b1;
          if (handshake) begin
            word_lo <= s_data;
            busy    <= 1'b1;
            if (s_last) begin
              last_seen        <= 1'b1;
              s_ready          <= 1'b0;
              address_register <= addr;
              data_in_register <= REG_WIDTH'({16'h0000, s_data});
              cmd_register     <= CMD_WRITE;
              state            <= WR;
            end else begin
              state <= COLLECT_HI;
            end
          end
        end

        COLLECT_HI: begin
          if (handshake) begin
            last_seen        <= s_last;
            s_ready          <= 1'b0;
            address_register <= addr;
            data_in_register <= REG_WIDTH'({s_data, word_lo});
            cmd_register     <= CMD_WRITE;
            state            <= WR;
          end
        end

        WR: begin
          cmd_register <= CMD_NOP;
          state        <= WR_NOP;
        end

        WR_NOP: begin
          if (!last_seen) begin
            addr    <= addr + REG_WIDTH'(2);
            s_ready <= 1'b1;
            busy    <= phase;
            state   <= COLLECT_LO;
          end else if (!phase) begin
            str_base  <= next_str_base;
            addr      <= next_str_base;
            phase     <= 1'b1;
            last_seen <= 1'b0;
            s_ready   <= 1'b1;
            state     <= COLLECT_LO;
          end else begin
            addr                      <= addr + REG_WIDTH'(2);
            last_seen                 <= 1'b0;
            start_cc_pointer_register <= str_base;
            cmd_register              <= CMD_START;
            timer                     <= '0;
            state                     <= START;
          end
        end

        START: begin
          // RUNNING wins over a timeout expiring in the same cycle.
          if (status_register == STATUS_RUNNING) begin
            cmd_register <= CMD_NOP;
            state        <= RUN;
          end else if (timer == TW'(START_TIMEOUT - 1)) begin
            cmd_register <= CMD_NOP;
            res_error    <= 1'b1;
            res_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        RUN: begin
          if (status_register != STATUS_RUNNING) begin
            res_accept <= (status_register == STATUS_ACCEPTED);
            res_error  <= (status_register != STATUS_ACCEPTED) &&
                          (status_register != STATUS_REJECTED);
            res_valid  <= 1'b1;
            state      <= DONE;
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid  <= 1'b0;
            res_accept <= 1'b0;
            res_error  <= 1'b0;
            phase      <= 1'b0;
            addr       <= CODE_BASE;
            s_ready    <= 1'b1;
            busy       <= 1'b0;
            state      <= COLLECT_LO;
          end
        end

        default: state <= COLLECT_LO;
      endcase
    end
  end

endmodule
